// File: rtl/fft_slice_packer.sv
// rtl/fft_slice_packer.sv - packs 8 consecutive 48-bit complex FFT samples into one 384-bit stream beat
module fft_slice_packer #(
    parameter int NUM_SLICES = 8,
    parameter int SLICE_W    = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SLICE_W-1:0]            s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [NUM_SLICES*SLICE_W-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          short_frame_err,
    output logic [15:0]                   beat_count
);

    localparam int BEAT_W = NUM_SLICES * SLICE_W;
    localparam int IDX_W  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLICES - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t              state, state_next;
    logic                ready_en;
    logic [IDX_W-1:0]    idx;
    logic [BEAT_W-1:0]   acc, acc_merged, load_data;
    logic                acc_last, load_last, load_out;
    logic                in_fire, out_fire, out_free, group_done;

    // ready_en keeps the input closed during reset and for the first cycle after it
    assign s_axis_tready = ready_en && (state == FILL);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = m_axis_tvalid && m_axis_tready;
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign group_done    = in_fire && ((idx == IDX_LAST) || s_axis_tlast);

    always_comb begin
        acc_merged = acc;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (idx == IDX_W'(k)) begin
                acc_merged[k*SLICE_W +: SLICE_W] = s_axis_tdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_data  = acc_merged;
        load_last  = s_axis_tlast;
        case (state)
            FILL: begin
                if (group_done) begin
                    if (out_free) begin
                        load_out = 1'b1;
                    end else begin
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                load_data = acc;
                load_last = acc_last;
                if (out_fire) begin
                    load_out   = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en        <= 1'b0;
            idx             <= '0;
            acc             <= '0;
            acc_last        <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            short_frame_err <= 1'b0;
            beat_count      <= '0;
        end else begin
            ready_en <= 1'b1;
            if (in_fire) begin
                if (group_done) begin
                    idx <= '0;
                    if (load_out) begin
                        acc <= '0;
                    end else begin
                        acc      <= acc_merged;
                        acc_last <= s_axis_tlast;
                    end
                end else begin
                    idx <= idx + 1'b1;
                    acc <= acc_merged;
                end
                if (s_axis_tlast && (idx != IDX_LAST)) begin
                    short_frame_err <= 1'b1;
                end
            end else if (load_out) begin
                // held group drained from FULL; unused slices of the next group must read zero
                acc <= '0;
            end

            if (load_out) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= load_data;
                m_axis_tlast  <= load_last;
            end else if (out_fire) begin
                m_axis_tvalid <= 1'b0;
            end

            if (out_fire) begin
                beat_count <= beat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_slice_packer.sv
// tb/tb_fft_slice_packer.sv - randomized and directed bench for fft_slice_packer against a queue-based model
module tb_fft_slice_packer;

    localparam int N  = 8;
    localparam int W  = 48;
    localparam int BW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  s_tdata;
    logic          s_tvalid, s_tlast, s_tready;
    logic [BW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic          short_frame_err;
    logic [15:0]   beat_count;

    fft_slice_packer #(.NUM_SLICES(N), .SLICE_W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_tdata),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready),
        .short_frame_err (short_frame_err),
        .beat_count      (beat_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // reference model: samples gathered in a queue, a beat emitted at 8 samples or tlast
    logic [W-1:0]  part_q[$];
    logic [BW-1:0] exp_data_q[$];
    logic          exp_last_q[$];
    logic          exp_err = 1'b0;
    int            hs_total = 0;
    int            hs_cyc_q[$];
    logic          hs_last_q[$];
    int            cyc = 0;
    logic          stalled = 1'b0;
    logic [BW-1:0] stall_data;
    logic          stall_last;

    function automatic logic [BW-1:0] pack(input logic [W-1:0] q[$]);
        logic [BW-1:0] p = '0;
        for (int k = 0; k < q.size(); k++) p[k*W +: W] = q[k];
        return p;
    endfunction

    function automatic logic [W-1:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            part_q.delete();
            exp_data_q.delete();
            exp_last_q.delete();
            exp_err = 1'b0;
            stalled = 1'b0;
        end else begin
            if (m_tvalid && m_tready) begin
                if (exp_data_q.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    chk("beat_data", m_tdata, exp_data_q.pop_front());
                    chk("beat_last", m_tlast, exp_last_q.pop_front());
                end
                hs_total++;
                hs_cyc_q.push_back(cyc);
                hs_last_q.push_back(m_tlast);
            end
            if (stalled) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_data", m_tdata, stall_data);
                chk("hold_last", m_tlast, stall_last);
            end
            stalled    = m_tvalid && !m_tready;
            stall_data = m_tdata;
            stall_last = m_tlast;
            if (s_tvalid && s_tready) begin
                part_q.push_back(s_tdata);
                if (s_tlast || part_q.size() == N) begin
                    exp_data_q.push_back(pack(part_q));
                    exp_last_q.push_back(s_tlast);
                    if (part_q.size() < N) exp_err = 1'b1;
                    part_q.delete();
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last, output int waits);
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        waits    = 0;
        @(negedge clk);
        while (!s_tready && waits < 2000) begin
            waits++;
            @(negedge clk);
        end
        if (!s_tready) chk("send_timeout", 0, 1);
        sync();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int            w, stalls, h0;
        logic [W-1:0]  first, ninth;
        logic [BW-1:0] e;
        logic          done;

        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_err", short_frame_err, 0);
        chk("rst_beat_count", beat_count, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_first_cycle", s_tready, 0);
        @(negedge clk);
        chk("rdy_second_cycle", s_tready, 1);
        sync();

        // single full beat, latency and boundary slices
        m_tready = 1'b1;
        for (int k = 1; k <= 7; k++) send({24'(k), 24'(2 * k)}, 1'b0, w);
        @(negedge clk);
        chk("t1_valid_early", m_tvalid, 0);
        sync();
        send({24'(8), 24'(16)}, 1'b0, w);
        @(negedge clk);
        chk("t1_valid_lat", m_tvalid, 1);
        chk("t1_slice0", m_tdata[47:0], 48'h000001000002);
        chk("t1_slice7", m_tdata[383:336], 48'h000008000010);
        sync();
        @(negedge clk);
        chk("t1_beat_count", beat_count, 1);
        sync();

        // 24 continuous samples: three beats 8 clocks apart
        hs_cyc_q.delete(); hs_last_q.delete();
        stalls = 0;
        for (int i = 0; i < 24; i++) begin
            send(rnd48(), i == 23, w);
            stalls += w;
        end
        repeat (3) sync();
        chk("t2_no_stall", stalls, 0);
        chk("t2_beats", hs_cyc_q.size(), 3);
        if (hs_cyc_q.size() == 3) begin
            chk("t2_gap01", hs_cyc_q[1] - hs_cyc_q[0], 8);
            chk("t2_gap12", hs_cyc_q[2] - hs_cyc_q[1], 8);
            chk("t2_last0", hs_last_q[0], 0);
            chk("t2_last1", hs_last_q[1], 0);
            chk("t2_last2", hs_last_q[2], 1);
        end
        chk("t2_err", short_frame_err, 0);

        // downstream stalled: second group parks in the accumulator
        m_tready = 1'b0;
        first = rnd48();
        ninth = rnd48();
        for (int i = 0; i < 16; i++) send(i == 0 ? first : (i == 8 ? ninth : rnd48()), 1'b0, w);
        @(negedge clk);
        chk("t3_rdy_full", s_tready, 0);
        chk("t3_valid", m_tvalid, 1);
        chk("t3_beat1_s0", m_tdata[47:0], first);
        sync();
        m_tready = 1'b1;
        @(negedge clk);
        chk("t3_rdy_drain_edge", s_tready, 0);
        sync();
        @(negedge clk);
        chk("t3_rdy_back", s_tready, 1);
        chk("t3_valid_b2", m_tvalid, 1);
        chk("t3_beat2_s0", m_tdata[47:0], ninth);
        sync();

        // short frame of three samples
        m_tready = 1'b0;
        send(48'h7FFFFF800000, 1'b0, w);
        send(48'h123456FEDCBA, 1'b0, w);
        send(48'hFFFFFF000001, 1'b1, w);
        @(negedge clk);
        e = {240'd0, 48'hFFFFFF000001, 48'h123456FEDCBA, 48'h7FFFFF800000};
        chk("t4_valid", m_tvalid, 1);
        chk("t4_data", m_tdata, e);
        chk("t4_last", m_tlast, 1);
        chk("t4_err", short_frame_err, 1);
        sync();
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send(rnd48(), i == 7, w);
        repeat (3) sync();
        chk("t4_err_sticky", short_frame_err, 1);
        chk("t4_err_model", short_frame_err, exp_err);

        // reset with a pending beat and a partial accumulator
        m_tready = 1'b0;
        for (int i = 0; i < 13; i++) send(rnd48(), 1'b0, w);
        h0 = hs_total;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_s_tready", s_tready, 0);
        chk("t5_m_tvalid", m_tvalid, 0);
        chk("t5_m_tlast", m_tlast, 0);
        chk("t5_m_tdata", m_tdata, 0);
        chk("t5_err", short_frame_err, 0);
        chk("t5_beat_count", beat_count, 0);
        sync();
        sync();
        rst = 1'b0;
        m_tready = 1'b1;
        chk("t5_no_handshake", hs_total, h0);
        first = rnd48();
        for (int i = 0; i < 8; i++) send(i == 0 ? first : rnd48(), 1'b0, w);
        @(negedge clk);
        chk("t5_valid", m_tvalid, 1);
        chk("t5_slice0", m_tdata[47:0], first);
        sync();
        @(negedge clk);
        chk("t5_beat_count_after", beat_count, 1);
        sync();

        // random valid/ready stress
        rst = 1'b1;
        sync();
        sync();
        rst = 1'b0;
        sync();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8000; i++) begin
                    if ($urandom_range(0, 3) == 0) sync();
                    send(rnd48(), (i % 8 == 7) && ($urandom_range(0, 3) == 0), w);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_tready = 1'($urandom_range(0, 1));
                    sync();
                end
            end
        join
        m_tready = 1'b1;
        repeat (10) sync();
        chk("t6_beat_count", beat_count, 1000);
        chk("t6_pending_beats", exp_data_q.size(), 0);
        chk("t6_partial", part_q.size(), 0);
        chk("t6_err", short_frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
